lcd_spi_sink: RTL

- Receive-side counterpart of the LCD SPI link: snoops the 4-wire write-only panel bus (SCL, SDA, DC, CS_n, RST_n) that the LCD driver produces.
- Decodes the command stream (CASET, RASET, RAMWR) and tracks the panel address window.
- Emits one strobe per received RGB565 pixel, carrying its x/y coordinate.
- Sits beside the panel for loopback self-check, or in front of a frame mirror that copies the picture to another display.

---
 rtl/lcd_spi_sink.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_spi_sink.sv
// Receive-side decoder for the write-only LCD SPI bus.
// Tracks CASET/RASET/RAMWR and emits one strobe per RGB565 pixel.
module lcd_spi_sink #(
    parameter int LCD_W       = 132,
    parameter int LCD_H       = 162,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_clk_in,
    input  logic        lcd_data_in,
    input  logic        lcd_dc_in,
    input  logic        lcd_cs_n_in,
    input  logic        lcd_rst_n_in,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done
);

    localparam logic [7:0] XE_RST = 8'(LCD_W - 1);
    localparam logic [7:0] YE_RST = 8'(LCD_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] prst_sync;

    logic scl_s, sda_s, dc_s, cs_s, prst_s;
    logic scl_q, cs_q;
    logic take;

    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_vld;
    logic [7:0] byte_q;
    logic       dc_q;

    state_t     state, state_nx;
    logic [1:0] pidx, pidx_nx;
    logic [7:0] xs, xs_nx, xe, xe_nx;
    logic [7:0] ys, ys_nx, ye, ye_nx;
    logic [7:0] cur_x, cur_x_nx;
    logic [7:0] cur_y, cur_y_nx;
    logic       half, half_nx;
    logic [7:0] hi, hi_nx;

    logic        cmd_valid_nx;
    logic [7:0]  cmd_byte_nx;
    logic        pix_valid_nx;
    logic [7:0]  pix_x_nx, pix_y_nx;
    logic [15:0] pix_data_nx;
    logic        frame_done_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= '0;
            sda_sync  <= '0;
            dc_sync   <= '0;
            cs_sync   <= '1;
            prst_sync <= '0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], lcd_clk_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], lcd_data_in};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], lcd_dc_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], lcd_cs_n_in};
            prst_sync <= {prst_sync[SYNC_STAGES-2:0], lcd_rst_n_in};
        end
    end

    assign scl_s  = scl_sync[SYNC_STAGES-1];
    assign sda_s  = sda_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign prst_s = prst_sync[SYNC_STAGES-1];

    // CS is judged one cycle late so a CS rise racing bit 8 keeps the byte
    assign take = scl_s & ~scl_q & ~cs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q    <= 1'b0;
            cs_q     <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_vld <= 1'b0;
            byte_q   <= '0;
            dc_q     <= 1'b0;
        end else begin
            scl_q    <= scl_s;
            cs_q     <= cs_s;
            byte_vld <= 1'b0;
            if (!prst_s) begin
                bit_cnt <= '0;
            end else if (take) begin
                shreg <= {shreg[5:0], sda_s};
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    byte_q   <= {shreg, sda_s};
                    dc_q     <= dc_s;
                    bit_cnt  <= '0;
                end else if (cs_s) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else if (cs_s) begin
                bit_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        pidx_nx       = pidx;
        xs_nx         = xs;
        xe_nx         = xe;
        ys_nx         = ys;
        ye_nx         = ye;
        cur_x_nx      = cur_x;
        cur_y_nx      = cur_y;
        half_nx       = half;
        hi_nx         = hi;
        cmd_valid_nx  = 1'b0;
        cmd_byte_nx   = cmd_byte;
        pix_valid_nx  = 1'b0;
        pix_x_nx      = pix_x;
        pix_y_nx      = pix_y;
        pix_data_nx   = pix_data;
        frame_done_nx = 1'b0;

        if (cs_s) half_nx = 1'b0;

        if (byte_vld && !dc_q) begin
            cmd_valid_nx = 1'b1;
            cmd_byte_nx  = byte_q;
            half_nx      = 1'b0;
            pidx_nx      = '0;
            unique case (1'b1)
                (byte_q == 8'h2A): state_nx = S_CASET;
                (byte_q == 8'h2B): state_nx = S_RASET;
                (byte_q == 8'h2C): begin
                    state_nx = S_RAMWR;
                    cur_x_nx = xs;
                    cur_y_nx = ys;
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (byte_vld) begin
            unique case (state)
                S_IDLE: ;
                S_CASET, S_RASET: begin
                    pidx_nx = pidx + 2'd1;
                    if (pidx == 2'd1) begin
                        if (state == S_CASET) xs_nx = byte_q;
                        else                  ys_nx = byte_q;
                    end
                    if (pidx == 2'd3) begin
                        if (state == S_CASET) xe_nx = byte_q;
                        else                  ye_nx = byte_q;
                        state_nx = S_IDLE;
                    end
                end
                S_RAMWR: begin
                    if (!half) begin
                        hi_nx   = byte_q;
                        half_nx = 1'b1;
                    end else begin
                        half_nx       = 1'b0;
                        pix_valid_nx  = 1'b1;
                        pix_x_nx      = cur_x;
                        pix_y_nx      = cur_y;
                        pix_data_nx   = {hi, byte_q};
                        frame_done_nx = (cur_x == xe) && (cur_y == ye);
                        if (cur_x == xe) begin
                            cur_x_nx = xs;
                            cur_y_nx = (cur_y == ye) ? ys : cur_y + 8'd1;
                        end else begin
                            cur_x_nx = cur_x + 8'd1;
                        end
                    end
                end
            endcase
        end

        // Panel reset overrides everything and holds outputs at zero
        if (!prst_s) begin
            state_nx      = S_IDLE;
            pidx_nx       = '0;
            xs_nx         = '0;
            xe_nx         = XE_RST;
            ys_nx         = '0;
            ye_nx         = YE_RST;
            cur_x_nx      = '0;
            cur_y_nx      = '0;
            half_nx       = 1'b0;
            hi_nx         = '0;
            cmd_valid_nx  = 1'b0;
            cmd_byte_nx   = '0;
            pix_valid_nx  = 1'b0;
            pix_x_nx      = '0;
            pix_y_nx      = '0;
            pix_data_nx   = '0;
            frame_done_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pidx       <= '0;
            xs         <= '0;
            xe         <= XE_RST;
            ys         <= '0;
            ye         <= YE_RST;
            cur_x      <= '0;
            cur_y      <= '0;
            half       <= 1'b0;
            hi         <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            pidx       <= pidx_nx;
            xs         <= xs_nx;
            xe         <= xe_nx;
            ys         <= ys_nx;
            ye         <= ye_nx;
            cur_x      <= cur_x_nx;
            cur_y      <= cur_y_nx;
            half       <= half_nx;
            hi         <= hi_nx;
            cmd_valid  <= cmd_valid_nx;
            cmd_byte   <= cmd_byte_nx;
            pix_valid  <= pix_valid_nx;
            pix_x      <= pix_x_nx;
            pix_y      <= pix_y_nx;
            pix_data   <= pix_data_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule
